// File: rtl/alu_operand_stage.sv
// Operand fetch stage in front of the alu: register file, scoreboard, writeback
// bypass and a single valid/ready output register carrying x, y, operation, rd.
module alu_operand_stage #(
  parameter int word_len = 32,
  parameter int op_len   = 8,
  parameter int addr_len = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [op_len-1:0]   in_op,
  input  logic [addr_len-1:0] in_rs1,
  input  logic [addr_len-1:0] in_rs2,
  input  logic [addr_len-1:0] in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [word_len-1:0] x,
  output logic [word_len-1:0] y,
  output logic [op_len-1:0]   operation,
  output logic [addr_len-1:0] out_rd,
  input  logic                wb_en,
  input  logic [addr_len-1:0] wb_rd,
  input  logic [word_len-1:0] wb_data,
  input  logic                wb_ovf,
  input  logic                wb_neg,
  input  logic                wb_zer,
  output logic [2:0]          flags
);
  localparam int NREG = 2**addr_len;

  typedef struct packed {
    logic [word_len-1:0] x;
    logic [word_len-1:0] y;
    logic [op_len-1:0]   op;
    logic [addr_len-1:0] rd;
  } opnd_t;

  logic [NREG-1:0][word_len-1:0] rf_q;
  logic [NREG-1:0]               pend_q, pend_d;
  logic [2:0]                    flags_q;
  opnd_t                         out_q, out_d;
  logic                          vld_q;
  logic                          wb_hit;
  logic                          hazard, accept;
  logic                          haz1, haz2, hazd;

  assign wb_hit = wb_en && (wb_rd != '0);

  // A pending index is released early by a writeback landing in the same cycle.
  always_comb begin
    haz1 = pend_q[in_rs1] && !(wb_en && wb_rd == in_rs1);
    haz2 = pend_q[in_rs2] && !(wb_en && wb_rd == in_rs2);
    hazd = pend_q[in_rd]  && !(wb_en && wb_rd == in_rd);
  end

  assign hazard   = haz1 || haz2 || hazd;
  assign in_ready = (!vld_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_d    = out_q;
    out_d.op = in_op;
    out_d.rd = in_rd;
    if (in_rs1 == '0)                     out_d.x = '0;
    else if (wb_hit && wb_rd == in_rs1)   out_d.x = wb_data;
    else                                  out_d.x = rf_q[in_rs1];
    if (in_rs2 == '0)                     out_d.y = '0;
    else if (wb_hit && wb_rd == in_rs2)   out_d.y = wb_data;
    else                                  out_d.y = rf_q[in_rs2];
  end

  // Clear before set so an issue to the index being written back stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wb_hit)                   pend_d[wb_rd] = 1'b0;
    if (accept && in_rd != '0)    pend_d[in_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q    <= '0;
      pend_q  <= '0;
      flags_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (wb_en) flags_q <= {wb_ovf, wb_neg, wb_zer};
      if (wb_hit) rf_q[wb_rd] <= wb_data;
      if (accept) begin
        out_q <= out_d;
        vld_q <= 1'b1;
      end else if (out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign out_valid = vld_q;
  assign x         = out_q.x;
  assign y         = out_q.y;
  assign operation = out_q.op;
  assign out_rd    = out_q.rd;
  assign flags     = flags_q;
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter word_len, default 32: operand/result width in bits, SHALL match the downstream alu.
REQ-002 Parameter op_len, default 8: operation code width, SHALL match the downstream alu.
REQ-003 Parameter addr_len, default 4: register index width; register count = 2**addr_len.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream instruction present.
REQ-007 in_ready  output  1  stage accepts instruction this cycle.
REQ-008 in_op  input  op_len  operation code.
REQ-009 in_rs1, in_rs2  input  addr_len each  source register indices.
REQ-010 in_rd  input  addr_len  destination register index.
REQ-011 out_valid  output  1  operands valid for alu.
REQ-012 out_ready  input  1  downstream consumes operands.
REQ-013 x, y  output  word_len each  operands driving alu ports x, y.
REQ-014 operation  output  op_len  drives alu port operation.
REQ-015 out_rd  output  addr_len  destination index travelling with operands.
REQ-016 wb_en  input  1  writeback strobe.
REQ-017 wb_rd  input  addr_len  writeback destination index.
REQ-018 wb_data  input  word_len  writeback value (alu ans).
REQ-019 wb_ovf, wb_neg, wb_zer  input  1 each  alu did_overflow, is_negative, is_zero.
REQ-020 flags  output  3  status register {ovf, neg, zer}.

Function
REQ-021 Register file SHALL hold 2**addr_len words; register 0 SHALL read 0 and ignore writes.
REQ-022 Writeback SHALL write wb_data to wb_rd at the clock edge where wb_en=1 and wb_rd!=0.
REQ-023 flags SHALL load {wb_ovf, wb_neg, wb_zer} on every edge with wb_en=1, including wb_rd=0; otherwise hold.
REQ-024 Scoreboard: one pending bit per register; register 0 SHALL never be pending.
REQ-025 Hazard SHALL be asserted when in_rs1, in_rs2 or in_rd is pending and not cleared by a writeback to that index in the same cycle.
REQ-026 in_ready SHALL equal (!out_valid || out_ready) && !hazard, combinationally.
REQ-027 Accept = in_valid && in_ready; on accept, the output register SHALL load x, y, operation=in_op, out_rd=in_rd, and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-028 Source read with bypass: if wb_en=1 and wb_rd equals a nonzero source index in the accept cycle, that operand SHALL be wb_data; else the register file value.
REQ-029 On accept with in_rd!=0, pending[in_rd] SHALL set; on wb_en with wb_rd!=0, pending[wb_rd] SHALL clear; when both hit the same index in one cycle, set SHALL win.
REQ-030 With out_valid=1 and out_ready=0, x, y, operation, out_rd SHALL hold stable.
REQ-031 out_valid SHALL clear when out_ready=1 and no accept occurs in the same cycle; back-to-back accepts SHALL sustain one instruction per cycle.
REQ-032 Writeback to a non-pending register SHALL still update the register file and flags.
REQ-033 in_op SHALL pass through unmodified; the stage SHALL not decode it.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for clk, clear all registers, pending bits, flags, out_valid, x, y, operation, out_rd.
REQ-035 Reset mid-operation SHALL discard the in-flight instruction; in_ready SHALL be 1 during reset.
REQ-036 The first accept SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-037 Write r3=7, r4=-2 (0xFFFFFFFE) via wb; issue rs1=3, rs2=4, rd=5, op=0 -> next cycle out_valid=1, x=7, y=0xFFFFFFFE, operation=0, out_rd=5.
REQ-038 Issue rd=5, then rs1=5 with no wb -> in_ready=0; wb_en with wb_rd=5, wb_data=9 in the same cycle as the retry -> accept, x=9 (bypass).
REQ-039 Hold out_ready=0 with out_valid=1 for 3 cycles -> x, y, operation, out_rd unchanged, in_ready=0; release -> next instruction accepted.
REQ-040 wb_en with wb_rd=0, wb_data=0x55, wb_ovf=1, wb_neg=0, wb_zer=0 -> r0 reads 0, flags=3'b100.
REQ-041 Assert rst_n=0 between clock edges while out_valid=1 and r5 pending -> out_valid=0, flags=0 at once; after release, issuing rs1=5 is accepted with x=0.
REQ-042 Sweep all 5 ops with operands in -10..9 through stage into alu, out_ready=1 -> one result per cycle, ans matches the operation applied to operands.
